instr_mem: RTL and testbench

Parametrised, loadable instruction memory for the pipelined CPU's fetch stage; successor to the fixed combinational program ROM. Holds `2**ADDR_W` words of `DATA_W` bits, self-clears to NOP after reset, and accepts a program over a valid/ready load stream. Presents a registered, stallable fetch port with halt detection.

---
 rtl/instr_mem_pkg.sv | 13 +
 rtl/instr_mem_ram.sv | 22 ++
 rtl/instr_mem.sv | 111 +++++++++++
 tb/tb_instr_mem.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and default encodings for the loadable instruction memory.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_mem_ram.sv
// Storage array: one synchronous write port, one synchronous read port with enable.
module instr_mem_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem.sv
// Loadable instruction memory: self-clear after reset, valid/ready program load,
// registered stallable fetch port with halt detect.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int                 ADDR_W    = 5,
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD  = DEF_NOP_WORD,
  parameter logic [DATA_W-1:0]  HALT_WORD = DEF_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_valid,
  output logic              fetch_halt,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              busy,
  output logic              ld_err
);

  // ptr carries one extra bit so an overrun saturates at DEPTH instead of wrapping
  localparam logic [ADDR_W:0] PTR_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic              hs;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [DATA_W-1:0] rdata;

  assign hs    = ld_ready && ld_valid;
  assign we    = (state == ST_CLEAR) || (hs && !ptr[ADDR_W]);
  assign wdata = (state == ST_CLEAR) ? NOP_WORD : ld_data;
  assign re    = (state == ST_IDLE) && !ld_start && fetch_en;

  instr_mem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ptr[ADDR_W-1:0]),
    .wdata (wdata),
    .re    (re),
    .raddr (fetch_addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      ptr         <= '0;
      fetch_valid <= 1'b0;
      busy        <= 1'b1;
      ld_ready    <= 1'b0;
      ld_err      <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          fetch_valid <= 1'b0;
          ptr         <= ptr + 1'b1;
          if (ptr[ADDR_W-1:0] == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end
        end
        ST_IDLE: begin
          if (ld_start) begin
            state       <= ST_LOAD;
            ptr         <= {1'b0, ld_base};
            ld_err      <= 1'b0;
            busy        <= 1'b1;
            ld_ready    <= 1'b1;
            fetch_valid <= 1'b0;
          end else if (fetch_en) begin
            fetch_valid <= 1'b1;
          end
        end
        ST_LOAD: begin
          fetch_valid <= 1'b0;
          if (hs) begin
            if (ptr[ADDR_W]) ld_err <= 1'b1;
            if (ptr != PTR_MAX) ptr <= ptr + 1'b1;
            if (ld_last) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              ld_ready <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // The read register only updates on real fetches, so a stall holds the last word
  // while fetch_valid masks stale contents to NOP whenever nothing real was fetched.
  assign fetch_instr = fetch_valid ? rdata : NOP_WORD;
  assign fetch_halt  = fetch_valid && (fetch_instr == HALT_WORD);

endmodule

// File: tb/tb_instr_mem.sv
// Randomized bench for instr_mem against a behavioural memory model, plus literal spot checks.
module tb_instr_mem;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [4:0]  fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_valid, fetch_halt;
  logic        ld_start;
  logic [4:0]  ld_base;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready, busy, ld_err;

  int errors = 0;
  int checks = 0;

  instr_mem dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .fetch_valid(fetch_valid), .fetch_halt(fetch_halt),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .busy(busy), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain array plus "clear cycles left" and "load session open".
  logic [31:0] mem_m [32];
  int          clr_left;
  bit          loading;
  int          nxt;
  bit          err_m;
  logic [31:0] fi_m;
  bit          fv_m;
  bit          started = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      clr_left = 32; loading = 0; nxt = 0; err_m = 0; fi_m = NOP; fv_m = 0; started = 1;
    end else if (started) begin
      if (clr_left > 0) begin
        mem_m[32 - clr_left] = NOP;
        clr_left--;
        fi_m = NOP; fv_m = 0;
      end else if (loading) begin
        fi_m = NOP; fv_m = 0;
        if (ld_valid) begin
          if (nxt < 32) mem_m[nxt] = ld_data;
          else err_m = 1;
          nxt++;
          if (ld_last) loading = 0;
        end
      end else if (ld_start) begin
        loading = 1; nxt = int'(ld_base); err_m = 0; fi_m = NOP; fv_m = 0;
      end else if (fetch_en) begin
        fi_m = mem_m[fetch_addr]; fv_m = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("fetch_instr", fetch_instr, fi_m);
      chk("fetch_valid", 32'(fetch_valid), 32'(fv_m));
      chk("fetch_halt", 32'(fetch_halt), 32'(fv_m && fi_m == HALT));
      chk("busy", 32'(busy), 32'(clr_left > 0 || loading));
      chk("ld_ready", 32'(ld_ready), 32'(loading && clr_left == 0));
      chk("ld_err", 32'(ld_err), 32'(err_m));
    end
  end

  logic [31:0] words [8];

  task automatic do_load(input logic [4:0] base, input int n, input bit toggle);
    @(negedge clk); ld_start = 1; ld_base = base; fetch_en = 0;
    @(negedge clk); ld_start = 0;
    for (int i = 0; i < n; i++) begin
      if (toggle) begin ld_valid = 0; ld_data = 32'hDEAD_BEEF; @(negedge clk); end
      ld_valid = 1; ld_data = words[i]; ld_last = (i == n - 1);
      @(negedge clk);
    end
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic do_fetch(input logic [4:0] a, input logic [31:0] exp, input bit exp_halt);
    fetch_en = 1; fetch_addr = a;
    @(negedge clk);
    fetch_en = 0;
    chk($sformatf("lit_instr[%0d]", a), fetch_instr, exp);
    chk($sformatf("lit_valid[%0d]", a), 32'(fetch_valid), 32'd1);
    chk($sformatf("lit_halt[%0d]", a), 32'(fetch_halt), 32'(exp_halt));
  endtask

  task automatic reset_and_count(input string name);
    int n;
    rst_n = 0; ld_valid = 0; ld_last = 0; ld_start = 0; fetch_en = 1;
    @(negedge clk); rst_n = 1;
    chk({name, "_busy_rst"}, 32'(busy), 32'd1);
    chk({name, "_valid_rst"}, 32'(fetch_valid), 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 40);
    chk({name, "_clear_cycles"}, n, 32);
  endtask

  initial begin
    rst_n = 0; fetch_en = 0; fetch_addr = '0; ld_start = 0; ld_base = '0;
    ld_valid = 0; ld_data = '0; ld_last = 0;
    @(negedge clk);
    reset_and_count("init");
    do_fetch(5'd7, NOP, 0);

    words[0] = 32'h0080_0293; words[1] = 32'h00F0_0313; words[2] = HALT;
    do_load(5'd0, 3, 0);
    @(negedge clk);
    do_fetch(5'd0, 32'h0080_0293, 0);
    do_fetch(5'd1, 32'h00F0_0313, 0);
    do_fetch(5'd2, HALT, 1);

    // stall: address changes must not disturb the held word
    do_fetch(5'd1, 32'h00F0_0313, 0);
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 5'(i + 3);
      @(negedge clk);
      chk("hold_instr", fetch_instr, 32'h00F0_0313);
    end

    words[0] = 32'hA000_0001; words[1] = 32'hA000_0002;
    words[2] = 32'hA000_0003; words[3] = 32'hA000_0004;
    do_load(5'd30, 4, 0);
    @(negedge clk);
    chk("overrun_err", 32'(ld_err), 32'd1);
    do_fetch(5'd30, 32'hA000_0001, 0);
    do_fetch(5'd31, 32'hA000_0002, 0);
    do_fetch(5'd0, 32'h0080_0293, 0);

    for (int i = 0; i < 5; i++) words[i] = 32'hB000_0010 + 32'(i);
    do_load(5'd8, 5, 1);
    @(negedge clk);
    chk("err_cleared", 32'(ld_err), 32'd0);
    for (int i = 0; i < 5; i++) do_fetch(5'(8 + i), 32'hB000_0010 + 32'(i), 0);
    do_fetch(5'd13, NOP, 0);

    // randomized traffic; the per-cycle model compare does the checking
    for (int c = 0; c < 600; c++) begin
      fetch_en   = ($urandom_range(0, 3) != 0);
      fetch_addr = 5'($urandom_range(0, 31));
      ld_start   = ($urandom_range(0, 19) == 0);
      ld_base    = 5'($urandom_range(0, 31));
      ld_valid   = ($urandom_range(0, 1) == 1);
      ld_data    = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      ld_last    = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    ld_start = 0; ld_valid = 1; ld_last = 1;
    @(negedge clk);
    ld_valid = 0; ld_last = 0;

    // reset during a load session wipes the partial program
    words[0] = 32'hC000_0001; words[1] = 32'hC000_0002; words[2] = 32'hC000_0003;
    @(negedge clk); ld_start = 1; ld_base = 5'd4;
    @(negedge clk); ld_start = 0;
    for (int i = 0; i < 3; i++) begin ld_valid = 1; ld_data = words[i]; @(negedge clk); end
    reset_and_count("midload");
    for (int a = 0; a < 32; a++) do_fetch(5'(a), NOP, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
